// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC-8 link (receive checker and transmit
// generator): default LFSR geometry, polynomial, seed and the frame FSM states.
package crc_pkg;

  localparam int          DATA_BITS_DEF = 8;
  localparam int          CRC_WIDTH_DEF = 8;
  localparam logic [7:0]  POLY_DEF      = 8'h44;
  localparam logic [7:0]  SEED_DEF      = 8'hD8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc_state_e;

endpackage

// File: rtl/crc_lfsr.sv
// CRC LFSR shared by the receive checker and the transmit generator.
// Ports:
//   clk, rst  clock / synchronous active-high reset (reset loads SEED)
//   load      reload SEED (highest priority after reset)
//   step, d   advance the LFSR with data bit d
//   shift     shift right with zero fill, presenting the next CRC bit
//   bit_out   current LFSR bit 0 (next CRC bit to send / compare)
module crc_lfsr #(
  parameter int                   W    = 8,
  parameter logic [W-1:0]         POLY = 8'h44,
  parameter logic [W-1:0]         SEED = 8'hD8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic d,
  input  logic shift,
  output logic bit_out
);

  logic [W-1:0] lfsr;
  logic [W-1:0] stepped;
  logic         fb;

  // Feedback enters the top stage; every tap n folds it into stage n-1.
  always_comb begin
    stepped    = '0;
    fb         = d ^ lfsr[0];
    stepped[W-1] = fb;
    for (int n = 1; n < W; n++)
      stepped[n-1] = lfsr[n] ^ (POLY[n] & fb);
  end

  always_ff @(posedge clk) begin
    if (rst || load)  lfsr <= SEED;
    else if (step)    lfsr <= stepped;
    else if (shift)   lfsr <= {1'b0, lfsr[W-1:1]};
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/crc_rx_checker.sv
// Receive-side CRC checker: deserialises a payload (LSB first, Active),
// then compares the received CRC bits (LSB first, Crc_Valid) against the
// CRC recomputed over the payload, and reports a one-cycle verdict.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   Data, Active        serial payload bit and qualifier
//   Crc_In, Crc_Valid   serial CRC bit and qualifier
//   Rx_Byte             recovered payload (bit k = k-th payload bit)
//   Done                one-cycle verdict strobe
//   Crc_Ok, Crc_Err     verdict, held until next Done
//   Frame_Err           short payload or Active during CRC, held until next Done
module crc_rx_checker
  import crc_pkg::*;
#(
  parameter int                     DATA_BITS = DATA_BITS_DEF,
  parameter int                     CRC_WIDTH = CRC_WIDTH_DEF,
  parameter logic [CRC_WIDTH-1:0]   POLY      = POLY_DEF,
  parameter logic [CRC_WIDTH-1:0]   SEED      = SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Data,
  input  logic                 Active,
  input  logic                 Crc_In,
  input  logic                 Crc_Valid,
  output logic [DATA_BITS-1:0] Rx_Byte,
  output logic                 Done,
  output logic                 Crc_Ok,
  output logic                 Crc_Err,
  output logic                 Frame_Err
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;

  crc_state_e    state;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] crc_cnt;
  logic          mismatch;
  logic          lfsr_bit;
  logic          lfsr_load, lfsr_step, lfsr_shift;
  logic          crc_miss;

  // Active has priority over Crc_Valid everywhere; in CRC it is a framing error,
  // so the LFSR is only shifted on a clean CRC bit.
  assign lfsr_load  = (state == DONE);
  assign lfsr_step  = Active && (state == IDLE || state == DATA);
  assign lfsr_shift = (state == CRC) && Crc_Valid && !Active;
  assign crc_miss   = mismatch | (Crc_In ^ lfsr_bit);

  crc_lfsr #(.W(CRC_WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .d       (Data),
    .shift   (lfsr_shift),
    .bit_out (lfsr_bit)
  );

  // Verdict registers are written on the edge that enters DONE so they are
  // visible together with Done during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      crc_cnt   <= '0;
      mismatch  <= 1'b0;
      Rx_Byte   <= '0;
      Done      <= 1'b0;
      Crc_Ok    <= 1'b0;
      Crc_Err   <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Active) begin
            Rx_Byte <= {{(DATA_BITS-1){1'b0}}, Data};
            bit_cnt <= BW'(1);
            state   <= DATA;
          end
        end
        DATA: begin
          if (Active) begin
            Rx_Byte[bit_cnt] <= Data;
            if (bit_cnt == BW'(DATA_BITS-1)) begin
              state    <= CRC;
              crc_cnt  <= '0;
              mismatch <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            state     <= DONE;
            Done      <= 1'b1;
            Frame_Err <= 1'b1;
            Crc_Ok    <= 1'b0;
            Crc_Err   <= 1'b1;
          end
        end
        CRC: begin
          if (Active) begin
            state     <= DONE;
            Done      <= 1'b1;
            Frame_Err <= 1'b1;
            Crc_Ok    <= 1'b0;
            Crc_Err   <= 1'b1;
          end else if (Crc_Valid) begin
            mismatch <= crc_miss;
            if (crc_cnt == CW'(CRC_WIDTH-1)) begin
              state     <= DONE;
              Done      <= 1'b1;
              Frame_Err <= 1'b0;
              Crc_Ok    <= ~crc_miss;
              Crc_Err   <= crc_miss;
            end else begin
              crc_cnt <= crc_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_rx_checker.sv
// Self-checking bench for crc_rx_checker: directed frames plus randomised
// back-to-back traffic, CRCs taken from a right-shift Galois model.
module tb_crc_rx_checker;

  localparam int POLY_I = 'h44;
  localparam int SEED_I = 'hD8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Data = 1'b0, Active = 1'b0, Crc_In = 1'b0, Crc_Valid = 1'b0;
  logic [7:0] Rx_Byte;
  logic       Done, Crc_Ok, Crc_Err, Frame_Err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  crc_rx_checker dut (
    .clk       (clk),
    .rst       (rst),
    .Data      (Data),
    .Active    (Active),
    .Crc_In    (Crc_In),
    .Crc_Valid (Crc_Valid),
    .Rx_Byte   (Rx_Byte),
    .Done      (Done),
    .Crc_Ok    (Crc_Ok),
    .Crc_Err   (Crc_Err),
    .Frame_Err (Frame_Err)
  );

  // Reference CRC: classic reflected update, feedback mask = top bit plus the
  // polynomial taps moved down one stage.
  function automatic logic [7:0] model_crc(input logic [7:0] data);
    int l = SEED_I;
    int fbm = 'h80 | (POLY_I >> 1);
    for (int i = 0; i < 8; i++) begin
      int fb = ((data >> i) ^ l) & 1;
      l = (l >> 1) ^ (fb != 0 ? fbm : 0);
    end
    return l[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_payload(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      Active = 1'b1;
      Data   = d[i];
      tick();
    end
    Active = 1'b0;
    Data   = 1'b0;
  endtask

  // Drives nbits CRC bits; first_gap idle cycles before bit 0, random
  // 0..gap_max idle cycles before each later bit.
  task automatic send_crc(input logic [7:0] c, input int nbits, input int first_gap, input int gap_max);
    for (int i = 0; i < nbits; i++) begin
      int g = (i == 0) ? first_gap : int'($urandom_range(gap_max, 0));
      for (int k = 0; k < g; k++) tick();
      Crc_Valid = 1'b1;
      Crc_In    = c[i];
      tick();
      Crc_Valid = 1'b0;
      Crc_In    = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({Rx_Byte, Done, Crc_Ok, Crc_Err, Frame_Err} !== 12'h000)
      $display("FAIL reset_outputs got=%h want=000", {Rx_Byte, Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
  endtask

  task automatic test_zero_payload();
    logic [7:0] c = model_crc(8'h00);
    send_payload(8'h00, 8);
    send_crc(c, 8, 1, 0);
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1100)
      $display("FAIL zero_verdict got=%b want=1100", {Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
    checks++;
    if (Rx_Byte !== 8'h00) $display("FAIL zero_rx_byte got=%h want=00", Rx_Byte);
    else passed++;
    tick();
    checks++;
    if (Done !== 1'b0 || Crc_Ok !== 1'b1) $display("FAIL zero_done_pulse got=%b%b want=01", Done, Crc_Ok);
    else passed++;
  endtask

  task automatic test_bad_crc();
    logic [7:0] c = model_crc(8'h00) ^ 8'h08;
    send_payload(8'h00, 8);
    send_crc(c, 8, 1, 0);
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1010)
      $display("FAIL bad_crc_verdict got=%b want=1010", {Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
    tick();
  endtask

  task automatic test_idle_crc_valid();
    int seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      Crc_Valid = 1'b1;
      Crc_In    = 1'($urandom);
      tick();
      if (Done) seen_done++;
    end
    Crc_Valid = 1'b0;
    tick();
    checks++;
    if (seen_done != 0 || {Crc_Ok, Crc_Err, Frame_Err} !== 3'b010)
      $display("FAIL idle_crc_valid dones=%0d verdict=%b want dones=0 verdict=010",
               seen_done, {Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
  endtask

  task automatic test_reset_mid_crc();
    logic [7:0] d = 8'($urandom);
    send_payload(d, 8);
    send_crc(model_crc(d), 3, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({Rx_Byte, Done, Crc_Ok, Crc_Err, Frame_Err} !== 12'h000)
      $display("FAIL reset_mid_crc got=%h want=000", {Rx_Byte, Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
    d = 8'hA5;
    send_payload(d, 8);
    send_crc(model_crc(d), 8, 0, 2);
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1100 || Rx_Byte !== d)
      $display("FAIL post_reset_frame got=%b/%h want=1100/%h", {Done, Crc_Ok, Crc_Err, Frame_Err}, Rx_Byte, d);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 10; f++) begin
      logic [7:0] d = 8'($urandom);
      send_payload(d, 8);
      send_crc(model_crc(d), 8, int'($urandom_range(3, 0)), 3);
      checks++;
      if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1100 || Rx_Byte !== d)
        $display("FAIL b2b_frame%0d got=%b/%h want=1100/%h", f, {Done, Crc_Ok, Crc_Err, Frame_Err}, Rx_Byte, d);
      else passed++;
      tick();
    end
  endtask

  task automatic test_short_payload();
    logic [7:0] d = 8'h3C;
    send_payload(8'($urandom), 5);
    tick();
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1011)
      $display("FAIL short_payload got=%b want=1011", {Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
    tick();
    send_payload(d, 8);
    send_crc(model_crc(d), 8, 2, 1);
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1100 || Rx_Byte !== d)
      $display("FAIL after_short got=%b/%h want=1100/%h", {Done, Crc_Ok, Crc_Err, Frame_Err}, Rx_Byte, d);
    else passed++;
    tick();
  endtask

  task automatic test_active_in_crc();
    logic [7:0] d = 8'h96;
    send_payload(d, 8);
    send_crc(model_crc(d), 4, 1, 1);
    Active    = 1'b1;
    Crc_Valid = 1'b1;
    Crc_In    = 1'b0;
    tick();
    Active    = 1'b0;
    Crc_Valid = 1'b0;
    checks++;
    if ({Done, Crc_Ok, Crc_Err, Frame_Err} !== 4'b1011)
      $display("FAIL active_in_crc got=%b want=1011", {Done, Crc_Ok, Crc_Err, Frame_Err});
    else passed++;
    tick();
    tick();
    checks++;
    if (Done !== 1'b0 || Frame_Err !== 1'b1)
      $display("FAIL active_in_crc_hold got=%b%b want=01", Done, Frame_Err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_payload();
    test_bad_crc();
    test_idle_crc_valid();
    test_reset_mid_crc();
    test_back_to_back();
    test_short_payload();
    test_active_in_crc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
